// File: rtl/aes_key_expansion_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expansion_iter
// Function : Iterative AES-128/192/256 key schedule, one word per cycle, that
//            emits 128-bit round keys over a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expansion_iter #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_IDX_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          key_size,
    input  logic [255:0]        key,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [127:0]        rk,
    output logic [RK_IDX_W-1:0] rk_index,
    output logic                rk_last,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic                err
);

    localparam logic [7:0] c_sbox [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {c_sbox[x[31:24]], c_sbox[x[23:16]], c_sbox[x[15:8]], c_sbox[x[7:0]]};
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [255:0]          r_key;
    logic [2:0]            r_nk_m1;
    logic [RK_IDX_W-1:0]   r_nr;
    logic [RK_IDX_W-1:0]   r_round;
    logic [2:0]            r_i;
    logic [2:0]            r_kpos;
    logic                  r_expand;
    logic [7:0]            r_rcon;
    logic [31:0]           r_hist [8];
    logic [31:0]           r_stage [3];
    logic [127:0]          r_rk;
    logic [RK_IDX_W-1:0]   r_rk_index;
    logic                  r_rk_last;
    logic                  r_rk_valid;
    logic                  r_key_ready;
    logic                  r_err;

    logic [2:0]            w_req_nk_m1;
    logic [RK_IDX_W-1:0]   w_req_nr;
    int                    w_req_bits;
    logic                  w_bad_req;
    logic [31:0]           w_key_word;
    logic                  w_rot_step;
    logic                  w_sub_step;
    logic [31:0]           w_sub_in;
    logic [31:0]           w_sub_out;
    logic [31:0]           w_t;
    logic [31:0]           w_word;
    logic                  w_group_end;
    logic                  w_advance;
    logic                  w_last_group;
    logic [7:0]            w_xtime;

    always_comb begin
        w_req_nk_m1 = 3'd7;
        w_req_nr    = RK_IDX_W'(14);
        w_req_bits  = 256;
        case (key_size)
            2'b00: begin
                w_req_nk_m1 = 3'd3;
                w_req_nr    = RK_IDX_W'(10);
                w_req_bits  = 128;
            end
            2'b01: begin
                w_req_nk_m1 = 3'd5;
                w_req_nr    = RK_IDX_W'(12);
                w_req_bits  = 192;
            end
            default: ;
        endcase
    end

    assign w_bad_req = (key_size == 2'b11) || (w_req_bits > MAX_KEY_BITS);

    // Key word i sits at bits [32*(7-i) +: 32] of the left-aligned key.
    assign w_key_word   = r_key[{~r_i, 5'd0} +: 32];
    assign w_rot_step   = r_expand && (r_kpos == 3'd0);
    assign w_sub_step   = r_expand && (r_nk_m1 == 3'd7) && (r_kpos == 3'd4);
    assign w_sub_in     = w_rot_step ? {r_hist[0][23:0], r_hist[0][31:24]} : r_hist[0];
    assign w_sub_out    = sub_word(w_sub_in);
    assign w_t          = w_rot_step ? (w_sub_out ^ {r_rcon, 24'h0}) :
                          w_sub_step ? w_sub_out : r_hist[0];
    assign w_word       = r_expand ? (r_hist[r_nk_m1] ^ w_t) : w_key_word;
    assign w_group_end  = (r_i[1:0] == 2'b11);
    assign w_advance    = (r_state == ST_GEN) && (!w_group_end || !r_rk_valid || rk_ready);
    assign w_last_group = (r_round == r_nr);
    assign w_xtime      = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_nk_m1     <= 3'd3;
            r_nr        <= '0;
            r_round     <= '0;
            r_i         <= '0;
            r_kpos      <= '0;
            r_expand    <= 1'b0;
            r_rcon      <= 8'h01;
            r_rk        <= '0;
            r_rk_index  <= '0;
            r_rk_last   <= 1'b0;
            r_rk_valid  <= 1'b0;
            r_key_ready <= 1'b1;
            r_err       <= 1'b0;
            for (int k = 0; k < 8; k++) r_hist[k] <= '0;
            for (int k = 0; k < 3; k++) r_stage[k] <= '0;
        end else begin
            r_err <= 1'b0;
            if (r_rk_valid && rk_ready) r_rk_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (key_valid) begin
                        if (w_bad_req) begin
                            r_err <= 1'b1;
                        end else begin
                            r_key       <= key;
                            r_nk_m1     <= w_req_nk_m1;
                            r_nr        <= w_req_nr;
                            r_round     <= '0;
                            r_i         <= '0;
                            r_kpos      <= '0;
                            r_expand    <= 1'b0;
                            r_rcon      <= 8'h01;
                            r_key_ready <= 1'b0;
                            r_state     <= ST_GEN;
                        end
                    end
                end
                ST_GEN: begin
                    if (w_advance) begin
                        r_hist[0] <= w_word;
                        for (int k = 1; k < 8; k++) r_hist[k] <= r_hist[k-1];
                        r_i <= r_i + 3'd1;
                        if (r_kpos == r_nk_m1) begin
                            r_kpos   <= '0;
                            r_expand <= 1'b1;
                        end else begin
                            r_kpos <= r_kpos + 3'd1;
                        end
                        if (w_rot_step) r_rcon <= w_xtime;
                        if (!w_group_end) begin
                            r_stage[0] <= r_stage[1];
                            r_stage[1] <= r_stage[2];
                            r_stage[2] <= w_word;
                        end else begin
                            r_rk       <= {r_stage[0], r_stage[1], r_stage[2], w_word};
                            r_rk_valid <= 1'b1;
                            r_rk_index <= r_round;
                            r_rk_last  <= w_last_group;
                            r_round    <= r_round + 1'b1;
                            if (w_last_group) r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_rk_valid && rk_ready) begin
                        r_state     <= ST_IDLE;
                        r_key_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign key_ready = r_key_ready;
    assign rk        = r_rk;
    assign rk_index  = r_rk_index;
    assign rk_last   = r_rk_last;
    assign rk_valid  = r_rk_valid;
    assign err       = r_err;

endmodule
`default_nettype wire
